// File: rtl/wb_master_param.sv
// Single-request Wishbone master bridging a simple valid/stall request port
// to N_SLAVE Wishbone slaves selected by an address field.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   vy_adres_i          : request address (slave select + bus address)
//   vy_veri_i           : request write data
//   vy_veri_maske_i     : byte mask (non-zero mask means write)
//   vy_sec_i            : request valid
//   vy_veri_o           : read data of the last completed request
//   vy_durdur_o         : stall, high while a request is being served
//   vy_hata_o           : error flag of the last completed request
//   adr_o, dat_o, sel_o : Wishbone address, write data, byte select
//   we_o, stb_o         : Wishbone write enable and strobe
//   cyc_o               : one cycle line per slave
//   ack_i, err_i        : per-slave acknowledge and error
//   dat_i               : per-slave read data, slave k at [32k+31:32k]

module wb_master_param #(
   parameter int N_SLAVE = 3,
   parameter int SEC_LSB = 16,
   parameter int SEC_W   = 2,
   parameter int ADR_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [31:0]             vy_adres_i,
   input  logic [31:0]             vy_veri_i,
   input  logic [3:0]              vy_veri_maske_i,
   input  logic                    vy_sec_i,
   output logic [31:0]             vy_veri_o,
   output logic                    vy_durdur_o,
   output logic                    vy_hata_o,
   output logic [ADR_W-1:0]        adr_o,
   output logic [31:0]             dat_o,
   output logic                    we_o,
   output logic                    stb_o,
   output logic [3:0]              sel_o,
   output logic [N_SLAVE-1:0]      cyc_o,
   input  logic [N_SLAVE-1:0]      ack_i,
   input  logic [N_SLAVE-1:0]      err_i,
   input  logic [32*N_SLAVE-1:0]   dat_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_DONE
   } state_t;

   // At least one bit so TIMEOUT=0 still yields a legal counter.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SEC_W:0] N_SLV = N_SLAVE[SEC_W:0];

   state_t             state_q, state_d;
   logic [ADR_W-1:0]   adr_q, adr_d;
   logic [31:0]        dat_q, dat_d;
   logic [3:0]         sel_q, sel_d;
   logic [SEC_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        veri_q, veri_d;
   logic               hata_q, hata_d;

   logic [SEC_W-1:0]   req_idx;
   logic               req_mapped;
   logic               sel_ack;
   logic               sel_err;
   logic [31:0]        sel_dat;
   logic [CNT_W-1:0]   cnt_inc;
   logic               cnt_sat;
   logic               tmo_hit;
   logic               unused_ok;

   assign req_idx    = vy_adres_i[SEC_LSB +: SEC_W];
   assign req_mapped = ({1'b0, req_idx} < N_SLV);
   assign unused_ok  = ^vy_adres_i;

   // Only the slave that owns the transfer may end it.
   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_dat = '0;
      for (int k = 0; k < N_SLAVE; k++) begin
         if (idx_q == SEC_W'(k)) begin
            sel_ack = ack_i[k];
            sel_err = err_i[k];
            sel_dat = dat_i[32*k +: 32];
         end
      end
   end

   // Saturating counter; the hit test looks at the value after this
   // cycle so cyc drops on the same edge the count reaches TIMEOUT.
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign cnt_sat = &cnt_q;
   assign tmo_hit = (TIMEOUT != 0) && !cnt_sat &&
                    (cnt_inc == CNT_W'(TIMEOUT));

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      veri_d  = veri_q;
      hata_d  = hata_q;
      unique case (state_q)
         S_IDLE: begin
            if (vy_sec_i) begin
               adr_d = vy_adres_i[ADR_W-1:0];
               dat_d = vy_veri_i;
               sel_d = vy_veri_maske_i;
               idx_d = req_idx;
               cnt_d = '0;
               if (req_mapped) begin
                  state_d = S_BUS;
               end else begin
                  state_d = S_DONE;
                  veri_d  = '0;
                  hata_d  = 1'b1;
               end
            end
         end
         S_BUS: begin
            if (!cnt_sat) begin
               cnt_d = cnt_inc;
            end
            if (sel_err) begin
               state_d = S_DONE;
               veri_d  = '0;
               hata_d  = 1'b1;
            end else if (sel_ack) begin
               state_d = S_DONE;
               veri_d  = sel_dat;
               hata_d  = 1'b0;
            end else if (tmo_hit) begin
               state_d = S_DONE;
               veri_d  = '0;
               hata_d  = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         veri_q  <= '0;
         hata_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         veri_q  <= veri_d;
         hata_q  <= hata_d;
      end
   end

   always_comb begin
      cyc_o = '0;
      for (int k = 0; k < N_SLAVE; k++) begin
         cyc_o[k] = (state_q == S_BUS) && (idx_q == SEC_W'(k));
      end
   end

   assign stb_o       = (state_q == S_BUS);
   assign vy_durdur_o = ((state_q == S_IDLE) && vy_sec_i) ||
                        (state_q == S_BUS);
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign sel_o       = sel_q;
   assign we_o        = |sel_q;
   assign vy_veri_o   = veri_q;
   assign vy_hata_o   = hata_q;

endmodule

// File: tb/tb_wb_master_param.sv
// Directed vector bench for wb_master_param (N_SLAVE=3, TIMEOUT=4).
// Table of transactions plus hand-written reset and back-to-back cases.

module tb_wb_master_param;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] vy_adres_i;
   logic [31:0] vy_veri_i;
   logic [3:0]  vy_veri_maske_i;
   logic        vy_sec_i;
   logic [31:0] vy_veri_o;
   logic        vy_durdur_o;
   logic        vy_hata_o;
   logic [7:0]  adr_o;
   logic [31:0] dat_o;
   logic        we_o;
   logic        stb_o;
   logic [3:0]  sel_o;
   logic [2:0]  cyc_o;
   logic [2:0]  ack_i;
   logic [2:0]  err_i;
   logic [95:0] dat_i;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   wb_master_param #(
      .N_SLAVE(3), .SEC_LSB(16), .SEC_W(2), .ADR_W(8), .TIMEOUT(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .vy_adres_i(vy_adres_i), .vy_veri_i(vy_veri_i),
      .vy_veri_maske_i(vy_veri_maske_i), .vy_sec_i(vy_sec_i),
      .vy_veri_o(vy_veri_o), .vy_durdur_o(vy_durdur_o),
      .vy_hata_o(vy_hata_o), .adr_o(adr_o), .dat_o(dat_o),
      .we_o(we_o), .stb_o(stb_o), .sel_o(sel_o), .cyc_o(cyc_o),
      .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
   );

   typedef struct {
      string       name;
      logic [31:0] adr;
      logic [31:0] wd;
      logic [3:0]  msk;
      int          ack_at;
      int          err_at;
      logic [2:0]  nack;
      logic [2:0]  nerr;
      logic [31:0] rd;
      logic [2:0]  exp_cyc;
      logic        exp_we;
      logic [31:0] exp_veri;
      logic        exp_hata;
      int          exp_bus;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic do_txn(input vec_t v);
      int         bus_n;
      int         stall_n;
      bit         done;
      logic [1:0] idx;
      idx = v.adr[17:16];
      @(negedge clk_i);
      vy_adres_i      = v.adr;
      vy_veri_i       = v.wd;
      vy_veri_maske_i = v.msk;
      vy_sec_i        = 1'b1;
      ack_i           = '0;
      err_i           = '0;
      for (int k = 0; k < 3; k++) begin
         dat_i[32*k +: 32] = (k == int'(idx)) ? v.rd : (~v.rd ^ 32'(k));
      end
      #1;
      chk({v.name, ".accept_stall"}, 32'(vy_durdur_o), 32'd1);
      bus_n   = 0;
      stall_n = 1;
      done    = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge clk_i);
         ack_i = v.nack;
         err_i = v.nerr;
         if (bus_n + 1 == v.ack_at) ack_i[idx] = 1'b1;
         if (bus_n + 1 == v.err_at) err_i[idx] = 1'b1;
         #1;
         if (vy_durdur_o) begin
            bus_n++;
            stall_n++;
            chk({v.name, ".cyc"}, 32'(cyc_o), 32'(v.exp_cyc));
            chk({v.name, ".stb"}, 32'(stb_o), 32'd1);
            if (bus_n == 1) begin
               chk({v.name, ".adr"}, 32'(adr_o), 32'(v.adr[7:0]));
               chk({v.name, ".we"}, 32'(we_o), 32'(v.exp_we));
               chk({v.name, ".sel"}, 32'(sel_o), 32'(v.msk));
               chk({v.name, ".dat_o"}, dat_o, v.wd);
            end
         end else begin
            ack_i = '0;
            err_i = '0;
            done  = 1'b1;
            chk({v.name, ".veri"}, vy_veri_o, v.exp_veri);
            chk({v.name, ".hata"}, 32'(vy_hata_o), 32'(v.exp_hata));
            chk({v.name, ".done_cyc"}, 32'(cyc_o), 32'd0);
            chk({v.name, ".done_stb"}, 32'(stb_o), 32'd0);
         end
      end
      chk({v.name, ".completed"}, 32'(done), 32'd1);
      chk({v.name, ".bus_cycles"}, 32'(bus_n), 32'(v.exp_bus));
      chk({v.name, ".stall_cycles"}, 32'(stall_n), 32'(v.exp_bus + 1));
   endtask

   task automatic idle(input int n, input logic [31:0] ev,
                       input logic eh);
      vy_sec_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         #1;
         chk("idle.stall", 32'(vy_durdur_o), 32'd0);
         chk("idle.cyc", 32'(cyc_o), 32'd0);
         chk("idle.veri_hold", vy_veri_o, ev);
         chk("idle.hata_hold", 32'(vy_hata_o), 32'(eh));
      end
   endtask

   vec_t tbl[$];
   vec_t b2b_a;
   vec_t b2b_b;
   vec_t post;

   initial begin
      tbl.push_back('{"rd_idx1", 32'h2001_0004, 32'h0, 4'b0000, 1, 0,
                      3'b000, 3'b000, 32'hCAFE_0001, 3'b010, 1'b0,
                      32'hCAFE_0001, 1'b0, 1});
      tbl.push_back('{"wr_idx2", 32'h2002_0010, 32'h1234_5678, 4'b0011,
                      3, 0, 3'b000, 3'b000, 32'h0BAD_F00D, 3'b100, 1'b1,
                      32'h0BAD_F00D, 1'b0, 3});
      tbl.push_back('{"unmapped", 32'h2003_0000, 32'h5555_AAAA, 4'b1111,
                      1, 0, 3'b000, 3'b000, 32'h1111_2222, 3'b000, 1'b1,
                      32'h0, 1'b1, 0});
      tbl.push_back('{"timeout", 32'h2000_00AA, 32'h0, 4'b0000, 0, 0,
                      3'b000, 3'b000, 32'h7777_7777, 3'b001, 1'b0,
                      32'h0, 1'b1, 4});
      tbl.push_back('{"err_ack", 32'h2000_0020, 32'h0, 4'b0000, 2, 2,
                      3'b000, 3'b000, 32'hDEAD_BEEF, 3'b001, 1'b0,
                      32'h0, 1'b1, 2});
      tbl.push_back('{"ignore_oth", 32'h2001_0030, 32'h0, 4'b0000, 3, 0,
                      3'b101, 3'b101, 32'hA5A5_0003, 3'b010, 1'b0,
                      32'hA5A5_0003, 1'b0, 3});
      tbl.push_back('{"err_only", 32'h2002_0040, 32'hFFFF_0000, 4'b0100,
                      0, 1, 3'b000, 3'b000, 32'h0000_9999, 3'b100, 1'b1,
                      32'h0, 1'b1, 1});
      tbl.push_back('{"wr_idx0", 32'h2000_00FC, 32'hABCD_EF01, 4'b1100,
                      1, 0, 3'b000, 3'b000, 32'h0101_0101, 3'b001, 1'b1,
                      32'h0101_0101, 1'b0, 1});

      b2b_a = '{"b2b_0", 32'h2000_0050, 32'h0, 4'b0000, 1, 0,
                3'b000, 3'b000, 32'h0000_00A0, 3'b001, 1'b0,
                32'h0000_00A0, 1'b0, 1};
      b2b_b = '{"b2b_1", 32'h2001_0054, 32'h0, 4'b0000, 2, 0,
                3'b001, 3'b000, 32'h0000_00B1, 3'b010, 1'b0,
                32'h0000_00B1, 1'b0, 2};
      post  = '{"post_rst", 32'h2002_0060, 32'h0, 4'b0000, 1, 0,
                3'b000, 3'b000, 32'h600D_600D, 3'b100, 1'b0,
                32'h600D_600D, 1'b0, 1};

      rst_i           = 1'b1;
      vy_adres_i      = '0;
      vy_veri_i       = '0;
      vy_veri_maske_i = '0;
      vy_sec_i        = 1'b0;
      ack_i           = '0;
      err_i           = '0;
      dat_i           = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rst.cyc", 32'(cyc_o), 32'd0);
      chk("rst.stb", 32'(stb_o), 32'd0);
      chk("rst.stall", 32'(vy_durdur_o), 32'd0);
      chk("rst.veri", vy_veri_o, 32'd0);
      chk("rst.hata", 32'(vy_hata_o), 32'd0);
      chk("rst.adr", 32'(adr_o), 32'd0);
      rst_i = 1'b0;

      foreach (tbl[i]) begin
         do_txn(tbl[i]);
         idle(2, tbl[i].exp_veri, tbl[i].exp_hata);
      end

      // Second request enters in the IDLE cycle right after DONE.
      do_txn(b2b_a);
      do_txn(b2b_b);
      idle(1, b2b_b.exp_veri, 1'b0);

      // Reset between edges while the bus cycle is open.
      @(negedge clk_i);
      vy_adres_i      = 32'h2001_0008;
      vy_veri_maske_i = 4'b0000;
      vy_sec_i        = 1'b1;
      @(negedge clk_i);
      #1;
      chk("mid.cyc_before", 32'(cyc_o), 32'b010);
      vy_sec_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk("mid.cyc", 32'(cyc_o), 32'd0);
      chk("mid.stb", 32'(stb_o), 32'd0);
      chk("mid.stall", 32'(vy_durdur_o), 32'd0);
      chk("mid.veri", vy_veri_o, 32'd0);
      chk("mid.hata", 32'(vy_hata_o), 32'd0);
      chk("mid.adr", 32'(adr_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      idle(1, 32'd0, 1'b0);
      do_txn(post);
      idle(1, post.exp_veri, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/wb_master_param.md
WB_MASTER_PARAM -- requirements
Module: wb_master_param

Interface
Parameters:
REQ-001 SHALL have parameter N_SLAVE, default 3, number of Wishbone slaves (1..2**SEC_W).
REQ-002 SHALL have parameter SEC_LSB, default 16, LSB of the slave-select field in vy_adres_i.
REQ-003 SHALL have parameter SEC_W, default 2, width of the slave-select field.
REQ-004 SHALL have parameter ADR_W, default 8, width of adr_o (taken from vy_adres_i[ADR_W-1:0]).
REQ-005 SHALL have parameter TIMEOUT, default 255, bus cycles waited for ack/err before abort; 0 disables.
Ports:
REQ-006 SHALL have: clk_i  in  1  single clock, all state on rising edge.
REQ-007 SHALL have: rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have: vy_adres_i in 32, vy_veri_i in 32, vy_veri_maske_i in 4, vy_sec_i in 1  (request address, write data, byte mask, request valid).
REQ-009 SHALL have: vy_veri_o out 32 read data; vy_durdur_o out 1 stall; vy_hata_o out 1 error flag.
REQ-010 SHALL have: adr_o out ADR_W, dat_o out 32, we_o out 1, stb_o out 1, sel_o out 4.
REQ-011 SHALL have: cyc_o out N_SLAVE, ack_i in N_SLAVE, err_i in N_SLAVE, dat_i in 32*N_SLAVE (slave k at bits [32k+31:32k]).

Function
REQ-012 SHALL implement FSM IDLE, BUS, DONE.
REQ-013 Slave index idx = vy_adres_i[SEC_LSB+SEC_W-1:SEC_LSB]; mapped iff idx < N_SLAVE.
REQ-014 IDLE with vy_sec_i=1: register address, data, mask, idx; next BUS if mapped, else DONE with error.
REQ-015 vy_durdur_o SHALL be combinational: 1 when (IDLE and vy_sec_i) or BUS; 0 in DONE and idle.
REQ-016 In BUS: stb_o=1, cyc_o[idx_r]=1, other cyc_o bits 0; adr_o/dat_o/sel_o from registers; we_o = OR of registered mask.
REQ-017 Outside BUS: stb_o=0, cyc_o all 0; adr_o/dat_o/sel_o/we_o hold registered values.
REQ-018 BUS with ack_i[idx_r]=1: capture dat_i slice idx_r into vy_veri_o, hata=0, next DONE.
REQ-019 BUS with err_i[idx_r]=1: vy_veri_o=0, hata=1, next DONE; err wins over simultaneous ack.
REQ-020 ack_i/err_i bits of non-selected slaves SHALL be ignored.
REQ-021 Timeout counter cleared on entering BUS, increments each BUS cycle; when TIMEOUT!=0 and count reaches TIMEOUT with no ack/err: vy_veri_o=0, hata=1, next DONE (cyc dropped at the same edge).
REQ-022 Counter width SHALL be clog2(TIMEOUT+1), minimum 1; it SHALL NOT wrap.
REQ-023 DONE lasts exactly one cycle: vy_veri_o/vy_hata_o valid, vy_durdur_o=0; next IDLE unconditionally; vy_sec_i in DONE is the completing request, not a new one.
REQ-024 vy_veri_o and vy_hata_o SHALL hold their values until the next completion.
REQ-025 Latency: mapped access with ack in first BUS cycle completes in 3 cycles (accept, BUS, DONE); unmapped in 2 cycles.
REQ-026 Back-to-back: vy_sec_i=1 in the IDLE cycle after DONE SHALL be accepted with no gap.

Reset
REQ-027 rst_i=1 SHALL asynchronously force IDLE, stb_o=0, cyc_o=0, vy_durdur_o=0 (unless REQ-015 applies after release), vy_veri_o=0, vy_hata_o=0, counter=0, registered address/data/mask=0.
REQ-028 Reset during BUS SHALL drop cyc_o/stb_o immediately without waiting for ack; the aborted request is not completed.

Verification
REQ-029 Read 0x2001_0004 (idx 1), mask 0, ack_i[1] on first BUS cycle, dat_i slice1=0xCAFE_0001 -> cyc_o=3'b010 one cycle, adr_o=0x04, we_o=0, DONE: vy_veri_o=0xCAFE_0001, hata=0, stall high exactly 2 cycles.
REQ-030 Write 0x2002_0010 (idx 2), data 0x1234_5678, mask 4'b0011, ack after 3 BUS cycles -> we_o=1, sel_o=0011, dat_o=0x1234_5678, stall high 4 cycles, hata=0.
REQ-031 Address 0x2003_0000 (idx 3 >= N_SLAVE) -> no cyc_o/stb_o, DONE next cycle with hata=1, vy_veri_o=0.
REQ-032 TIMEOUT=4, slave never acks -> cyc_o high 4 cycles, then DONE with hata=1; ack_i/err_i both asserted on idx in other run -> hata=1.
REQ-033 Assert rst_i mid-BUS (between clock edges) -> cyc_o/stb_o low before next edge, FSM IDLE, vy_veri_o=0; new request after release completes normally.
REQ-034 Two back-to-back reads idx0 then idx1, ack_i[0] also pulsed during second transfer -> second result taken only from ack_i[1]/slice1, no idle gap between transactions.
